// File: rtl/game_timer_bcd.sv
// ---------------------------------------------------------------------------
// game_timer_bcd
//
// Countdown game timer. DIGITS BCD digits count down once per second
// (CLOCK_FREQUENCY ClockIn cycles) from a loadable start value to zero.
// Each digit drives one active-low seven-segment display. Time-up is flagged
// to the game controller with a level (TimeUp) and a one-cycle pulse (Expired).
//
// Parameters:
//   CLOCK_FREQUENCY  ClockIn cycles per one-second tick (>= 2)
//   DIGITS           number of BCD digits / displays (1..4)
//   START_SECONDS    decimal value loaded at reset and on restart from DONE
//
// Ports:
//   ClockIn     in   system clock
//   Reset       in   asynchronous, active-high reset
//   Start       in   level; begins countdown from IDLE, restarts from DONE
//   Pause       in   level; freezes countdown while high in RUN
//   Load        in   level; loads LoadValue (digits > 9 clamp to 9), -> IDLE
//   LoadValue   in   BCD load value, digit 0 in [3:0]
//   CountValue  out  current BCD count, digit 0 in [3:0]
//   HexOut      out  active-low segments, digit i in [7i+6:7i], bit0 = a
//   Running     out  registered, high in RUN
//   TimeUp      out  registered, high in DONE
//   Expired     out  registered one-cycle pulse on entering DONE
//
// Command priority each cycle: Load > Start > Pause.
//
// Optional feature, macro LAST_TEN_BLINK_EN:
//   When defined, the display blanks during the second half of each second
//   while running with CountValue <= 10, and blinks "0" in DONE using a
//   free-running prescaler. When undefined, HexOut always shows CountValue.
//
// The FSM state is held in the internal signal `state` so that checkers can
// bind to it without changing the port list.
// ---------------------------------------------------------------------------
module game_timer_bcd #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int DIGITS          = 2,
    parameter int START_SECONDS   = 60
) (
    input  logic                  ClockIn,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Pause,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadValue,
    output logic [4*DIGITS-1:0]   CountValue,
    output logic [7*DIGITS-1:0]   HexOut,
    output logic                  Running,
    output logic                  TimeUp,
    output logic                  Expired
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int PW = $clog2(CLOCK_FREQUENCY);

    localparam logic [PW-1:0] PRESC_RELOAD = PW'(CLOCK_FREQUENCY - 1);
    localparam logic [PW-1:0] PRESC_ONE    = PW'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Decimal -> packed BCD, evaluated at elaboration time.
    function automatic logic [4*DIGITS-1:0] to_bcd(input int value);
        logic [4*DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam logic [4*DIGITS-1:0] START_BCD = to_bcd(START_SECONDS);

    // Active-low glyph for one BCD digit; non-decimal codes are blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]          state;
    logic [1:0]          state_n;
    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] count_n;
    logic [PW-1:0]       presc_q;
    logic [PW-1:0]       presc_n;
    logic                expired_n;

    // ------------------------------------------------------------------
    // BCD decrement with borrow chain (single cycle, all digits)
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] count_dec;
    logic                borrow;
    logic [3:0]          digit;

    always_comb begin
        count_dec = '0;
        borrow    = 1'b1;
        digit     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (!borrow) begin
                count_dec[4*i +: 4] = digit;
            end else if (digit == 4'd0) begin
                count_dec[4*i +: 4] = 4'd9;
            end else begin
                count_dec[4*i +: 4] = digit - 4'd1;
                borrow              = 1'b0;
            end
        end
    end

    // A tick on an already-zero count must not wrap to all nines.
    logic final_tick;
    assign final_tick = (count_dec == '0) || (count_q == '0);

    // ------------------------------------------------------------------
    // Load value with per-digit clamp to 9
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] load_clamped;

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = (LoadValue[4*i +: 4] > 4'd9) ? 4'd9
                                                                  : LoadValue[4*i +: 4];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        count_n = count_q;
        presc_n = presc_q;

        if (Load) begin
            state_n = ST_IDLE;
            count_n = load_clamped;
            presc_n = PRESC_RELOAD;
        end else if (Start && (state == ST_IDLE) && (count_q != '0)) begin
            state_n = ST_RUN;
            presc_n = PRESC_RELOAD;
        end else if (Start && (state == ST_DONE)) begin
            state_n = ST_RUN;
            count_n = START_BCD;
            presc_n = PRESC_RELOAD;
        end else if (state == ST_RUN) begin
            if (Pause) begin
                // Prescaler holds so the fractional second survives the pause.
                state_n = ST_PAUSED;
            end else if (presc_q == '0) begin
                presc_n = PRESC_RELOAD;
                if (final_tick) begin
                    count_n = '0;
                    state_n = ST_DONE;
                end else begin
                    count_n = count_dec;
                end
            end else begin
                presc_n = presc_q - PRESC_ONE;
            end
        end else if ((state == ST_PAUSED) && !Pause) begin
            state_n = ST_RUN;
        end
    end

    // Pulse only on the transition into DONE; Load beating the final tick
    // keeps state_n at IDLE, so no pulse is produced.
    assign expired_n = (state_n == ST_DONE) && (state != ST_DONE);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            count_q <= START_BCD;
            presc_q <= PRESC_RELOAD;
            Running <= 1'b0;
            TimeUp  <= 1'b0;
            Expired <= 1'b0;
        end else begin
            state   <= state_n;
            count_q <= count_n;
            presc_q <= presc_n;
            Running <= (state_n == ST_RUN);
            TimeUp  <= (state_n == ST_DONE);
            Expired <= expired_n;
        end
    end

    assign CountValue = count_q;

    // ------------------------------------------------------------------
    // Display blanking
    // ------------------------------------------------------------------
    logic blank;

`ifdef LAST_TEN_BLINK_EN
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLOCK_FREQUENCY / 2);

    // Free-running second counter so DONE can blink independently of the
    // countdown prescaler, which is frozen outside RUN.
    logic [PW-1:0] free_presc_q;

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            free_presc_q <= PRESC_RELOAD;
        end else if (free_presc_q == '0) begin
            free_presc_q <= PRESC_RELOAD;
        end else begin
            free_presc_q <= free_presc_q - PRESC_ONE;
        end
    end

    // CountValue <= 10: all digits above the tens are zero and the tens
    // digit is 0, or the tens digit is 1 with a zero units digit.
    logic       upper_zero;
    logic [3:0] tens;
    logic       le_ten;

    always_comb begin
        upper_zero = 1'b1;
        tens       = 4'd0;
        for (int i = 1; i < DIGITS; i++) begin
            if (i == 1) begin
                tens = count_q[4*i +: 4];
            end else if (count_q[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        le_ten = upper_zero &&
                 ((tens == 4'd0) || ((tens == 4'd1) && (count_q[3:0] == 4'd0)));
    end

    assign blank = ((state == ST_RUN) && le_ten && (presc_q < PRESC_HALF)) ||
                   ((state == ST_DONE) && (free_presc_q < PRESC_HALF));
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        HexOut = '1;
        for (int i = 0; i < DIGITS; i++) begin
            HexOut[7*i +: 7] = blank ? 7'b1111111 : seg7(count_q[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_game_timer_bcd.sv
// ---------------------------------------------------------------------------
// tb_game_timer_bcd
//
// Directed testbench for game_timer_bcd with CLOCK_FREQUENCY=4, DIGITS=2,
// START_SECONDS=12. Inputs are driven on the falling edge, outputs are
// sampled on the falling edge, so every check sits half a cycle away from
// the active rising edge. Edge numbering in comments: E0 is the rising edge
// that accepts a command, En is the n-th rising edge after it.
// ---------------------------------------------------------------------------
module tb_game_timer_bcd;

    logic        ClockIn;
    logic        Reset;
    logic        Start;
    logic        Pause;
    logic        Load;
    logic [7:0]  LoadValue;
    logic [7:0]  CountValue;
    logic [13:0] HexOut;
    logic        Running;
    logic        TimeUp;
    logic        Expired;

    int passed;
    int total;

    game_timer_bcd #(
        .CLOCK_FREQUENCY(4),
        .DIGITS(2),
        .START_SECONDS(12)
    ) dut (
        .ClockIn(ClockIn),
        .Reset(Reset),
        .Start(Start),
        .Pause(Pause),
        .Load(Load),
        .LoadValue(LoadValue),
        .CountValue(CountValue),
        .HexOut(HexOut),
        .Running(Running),
        .TimeUp(TimeUp),
        .Expired(Expired)
    );

    // Clock / reset
    initial begin
        ClockIn = 1'b0;
        forever #5 ClockIn = ~ClockIn;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge ClockIn);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Pause = 1'b0; Load = 1'b0; LoadValue = 8'h00;
        cyc(2);
        total++; if (CountValue !== 8'h12) $display("FAIL reset_count: got %h want %h", CountValue, 8'h12); else passed++;
        total++; if ({Running, TimeUp, Expired} !== 3'b000) $display("FAIL reset_flags: got %b want %b", {Running, TimeUp, Expired}, 3'b000); else passed++;
        Reset = 1'b0;
        cyc(20);
        total++; if (CountValue !== 8'h12) $display("FAIL idle_count: got %h want %h", CountValue, 8'h12); else passed++;
        total++; if ({Running, TimeUp} !== 2'b00) $display("FAIL idle_flags: got %b want %b", {Running, TimeUp}, 2'b00); else passed++;
        total++; if (HexOut[6:0] !== 7'b0100100) $display("FAIL idle_hex0: got %b want %b", HexOut[6:0], 7'b0100100); else passed++;
        total++; if (HexOut[13:7] !== 7'b1111001) $display("FAIL idle_hex1: got %b want %b", HexOut[13:7], 7'b1111001); else passed++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_countdown();
        Start = 1'b1;
        cyc(1);                                 // after E0
        Start = 1'b0;
        total++; if (Running !== 1'b1) $display("FAIL run_running: got %b want %b", Running, 1'b1); else passed++;
        cyc(3);                                 // after E3
        total++; if (CountValue !== 8'h12) $display("FAIL run_e3: got %h want %h", CountValue, 8'h12); else passed++;
        cyc(1);                                 // after E4
        total++; if (CountValue !== 8'h11) $display("FAIL run_e4: got %h want %h", CountValue, 8'h11); else passed++;
        cyc(4);                                 // after E8
        total++; if (CountValue !== 8'h10) $display("FAIL run_e8: got %h want %h", CountValue, 8'h10); else passed++;
        cyc(4);                                 // after E12, borrow
        total++; if (CountValue !== 8'h09) $display("FAIL run_borrow: got %h want %h", CountValue, 8'h09); else passed++;
        total++; if (HexOut !== {7'b1000000, 7'b0010000}) $display("FAIL run_hex09: got %b want %b", HexOut, {7'b1000000, 7'b0010000}); else passed++;
        cyc(35);                                // after E47
        total++; if (CountValue !== 8'h01) $display("FAIL run_e47: got %h want %h", CountValue, 8'h01); else passed++;
        total++; if (Expired !== 1'b0) $display("FAIL run_e47_expired: got %b want %b", Expired, 1'b0); else passed++;
        cyc(1);                                 // after E48
        total++; if (CountValue !== 8'h00) $display("FAIL zero_count: got %h want %h", CountValue, 8'h00); else passed++;
        total++; if ({Running, TimeUp, Expired} !== 3'b011) $display("FAIL zero_flags: got %b want %b", {Running, TimeUp, Expired}, 3'b011); else passed++;
        total++; if (HexOut !== {7'b1000000, 7'b1000000}) $display("FAIL zero_hex: got %b want %b", HexOut, {7'b1000000, 7'b1000000}); else passed++;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            total++; if ({CountValue, TimeUp, Expired} !== {8'h00, 2'b10}) $display("FAIL done_hold[%0d]: got %h/%b%b want 00/10", i, CountValue, TimeUp, Expired); else passed++;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pause();
        Start = 1'b1;                           // restart from DONE
        cyc(1);                                 // after E0
        Start = 1'b0;
        total++; if (CountValue !== 8'h12) $display("FAIL restart_count: got %h want %h", CountValue, 8'h12); else passed++;
        total++; if ({Running, TimeUp} !== 2'b10) $display("FAIL restart_flags: got %b want %b", {Running, TimeUp}, 2'b10); else passed++;
        cyc(4);                                 // after E4
        total++; if (CountValue !== 8'h11) $display("FAIL restart_e4: got %h want %h", CountValue, 8'h11); else passed++;
        cyc(2);                                 // two cycles into the second
        Pause = 1'b1;
        cyc(1);                                 // after E7
        total++; if (Running !== 1'b0) $display("FAIL paused_running: got %b want %b", Running, 1'b0); else passed++;
        cyc(9);                                 // after E16, pause held 10 cycles
        total++; if (CountValue !== 8'h11) $display("FAIL paused_count: got %h want %h", CountValue, 8'h11); else passed++;
        Pause = 1'b0;
        cyc(1);                                 // after E17
        total++; if ({Running, CountValue} !== {1'b1, 8'h11}) $display("FAIL resume_e17: got %b/%h want 1/11", Running, CountValue); else passed++;
        cyc(1);                                 // after E18
        total++; if (CountValue !== 8'h11) $display("FAIL resume_e18: got %h want %h", CountValue, 8'h11); else passed++;
        cyc(1);                                 // after E19
        total++; if (CountValue !== 8'h10) $display("FAIL resume_e19: got %h want %h", CountValue, 8'h10); else passed++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_load();
        LoadValue = 8'hF5;
        Load = 1'b1;
        cyc(1);
        Load = 1'b0;
        total++; if (CountValue !== 8'h95) $display("FAIL load_clamp_hi: got %h want %h", CountValue, 8'h95); else passed++;
        total++; if (Running !== 1'b0) $display("FAIL load_running: got %b want %b", Running, 1'b0); else passed++;
        LoadValue = 8'h3C;
        Load = 1'b1;
        cyc(1);
        Load = 1'b0;
        total++; if (CountValue !== 8'h39) $display("FAIL load_clamp_lo: got %h want %h", CountValue, 8'h39); else passed++;
        cyc(5);
        total++; if (CountValue !== 8'h39) $display("FAIL load_idle_hold: got %h want %h", CountValue, 8'h39); else passed++;
        Start = 1'b1;
        cyc(1);
        Start = 1'b0;
        total++; if (Running !== 1'b1) $display("FAIL load_start_running: got %b want %b", Running, 1'b1); else passed++;
        cyc(3);
        total++; if (CountValue !== 8'h39) $display("FAIL load_start_e3: got %h want %h", CountValue, 8'h39); else passed++;
        cyc(1);
        total++; if (CountValue !== 8'h38) $display("FAIL load_start_e4: got %h want %h", CountValue, 8'h38); else passed++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_vs_final_tick();
        LoadValue = 8'h02;
        Load = 1'b1;
        cyc(1);
        Load = 1'b0;
        Start = 1'b1;
        cyc(1);                                 // after E0
        Start = 1'b0;
        cyc(4);                                 // after E4
        total++; if (CountValue !== 8'h01) $display("FAIL race_e4: got %h want %h", CountValue, 8'h01); else passed++;
        cyc(3);                                 // after E7, final tick due at E8
        total++; if (Running !== 1'b1) $display("FAIL race_e7_running: got %b want %b", Running, 1'b1); else passed++;
        LoadValue = 8'h07;
        Load = 1'b1;
        Start = 1'b1;
        cyc(1);                                 // after E8
        Load = 1'b0;
        Start = 1'b0;
        total++; if (CountValue !== 8'h07) $display("FAIL race_count: got %h want %h", CountValue, 8'h07); else passed++;
        total++; if ({Running, TimeUp, Expired} !== 3'b000) $display("FAIL race_flags: got %b want %b", {Running, TimeUp, Expired}, 3'b000); else passed++;
        cyc(1);
        total++; if ({CountValue, Expired} !== {8'h07, 1'b0}) $display("FAIL race_after: got %h/%b want 07/0", CountValue, Expired); else passed++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_zero_start_ignored();
        LoadValue = 8'h00;
        Load = 1'b1;
        cyc(1);
        Load = 1'b0;
        Start = 1'b1;
        cyc(1);
        Start = 1'b0;
        cyc(5);
        total++; if ({CountValue, Running, TimeUp, Expired} !== {8'h00, 3'b000}) $display("FAIL zero_start: got %h/%b%b%b want 00/000", CountValue, Running, TimeUp, Expired); else passed++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_run();
        LoadValue = 8'h07;
        Load = 1'b1;
        cyc(1);
        Load = 1'b0;
        Start = 1'b1;
        cyc(1);                                 // after E0
        Start = 1'b0;
        cyc(5);                                 // after E5
        total++; if ({Running, CountValue} !== {1'b1, 8'h06}) $display("FAIL midrun_pre: got %b/%h want 1/06", Running, CountValue); else passed++;
        #2 Reset = 1'b1;                        // asynchronous, between edges
        #1;
        total++; if (CountValue !== 8'h12) $display("FAIL async_reset_count: got %h want %h", CountValue, 8'h12); else passed++;
        total++; if ({Running, TimeUp, Expired} !== 3'b000) $display("FAIL async_reset_flags: got %b want %b", {Running, TimeUp, Expired}, 3'b000); else passed++;
        cyc(1);
        Reset = 1'b0;
        cyc(5);
        total++; if ({CountValue, Running, Expired} !== {8'h12, 2'b00}) $display("FAIL post_reset_idle: got %h/%b%b want 12/00", CountValue, Running, Expired); else passed++;
    endtask

    // ------------------------------------------------------------------
    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_countdown();
        test_pause();
        test_load();
        test_load_vs_final_tick();
        test_zero_start_ignored();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
